// File: rtl/thee_clk_pulse_gen_pkg.sv
// Shared types and defaults for the burst clock pulse generator.
package thee_clk_pulse_gen_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/thee_phase_counter.sv
// Loadable down-counter with terminal-count flag; times both HIGH and LOW phases.
module thee_phase_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/thee_clk_pulse_gen.sv
// Burst clock generator: programmable high/low phase lengths with optional period count.
//
// state   | meaning
// --------+----------------------------------------------------
// IDLE    | stopped, clk_out low, waiting for en
// HIGH    | high phase, clk_out high for H cycles
// LOW     | low phase, clk_out low for L cycles; period ends here
module thee_clk_pulse_gen
    import thee_clk_pulse_gen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic [CNT_W-1:0] cfg_low,
    input  logic [CNT_W-1:0] cfg_count,
    output logic             clk_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] period_cnt
);

    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ALL1 = '1;

    state_t state, state_nxt;

    logic             pending;
    logic [CNT_W-1:0] pend_high, pend_low, pend_count;
    logic [CNT_W-1:0] act_high, act_low, act_count;
    logic [CNT_W-1:0] burst_n;
    logic [CNT_W-1:0] eff_high, eff_low, eff_count;
    logic [CNT_W-1:0] period_inc;
    logic             reached;

    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             tc;
    logic             enter_high;
    logic             start;
    logic             period_end;

    // Values that take effect on a HIGH entry: the pending set if one is waiting.
    assign eff_high  = pending ? ((pend_high == '0) ? ONE : pend_high) : act_high;
    assign eff_low   = pending ? ((pend_low  == '0) ? ONE : pend_low)  : act_low;
    assign eff_count = pending ? pend_count : act_count;

    assign period_inc = (period_cnt == ALL1) ? period_cnt : period_cnt + ONE;
    assign reached    = (burst_n != '0) && (period_inc >= burst_n);

    thee_phase_counter #(
        .CNT_W (CNT_W)
    ) u_phase (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .tc       (tc)
    );

    always_comb begin
        state_nxt  = state;
        load       = 1'b0;
        load_val   = '0;
        enter_high = 1'b0;
        start      = 1'b0;
        period_end = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en) begin
                    state_nxt  = ST_HIGH;
                    load       = 1'b1;
                    load_val   = eff_high - ONE;
                    enter_high = 1'b1;
                    start      = 1'b1;
                end
            end
            ST_HIGH: begin
                if (tc) begin
                    state_nxt = ST_LOW;
                    load      = 1'b1;
                    load_val  = act_low - ONE;
                end
            end
            ST_LOW: begin
                if (tc) begin
                    period_end = 1'b1;
                    if (reached || !en) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt  = ST_HIGH;
                        load       = 1'b1;
                        load_val   = eff_high - ONE;
                        enter_high = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            clk_out    <= 1'b0;
            done       <= 1'b0;
            period_cnt <= '0;
            pending    <= 1'b0;
            pend_high  <= '0;
            pend_low   <= '0;
            pend_count <= '0;
            act_high   <= ONE;
            act_low    <= ONE;
            act_count  <= '0;
            burst_n    <= '0;
        end else begin
            state   <= state_nxt;
            clk_out <= (state_nxt == ST_HIGH);
            done    <= (state != ST_IDLE) && (state_nxt == ST_IDLE);

            // Accept and apply are mutually exclusive: accepting needs !pending.
            if (enter_high && pending) begin
                act_high  <= eff_high;
                act_low   <= eff_low;
                act_count <= eff_count;
                pending   <= 1'b0;
            end else if (cfg_valid && !pending) begin
                pend_high  <= cfg_high;
                pend_low   <= cfg_low;
                pend_count <= cfg_count;
                pending    <= 1'b1;
            end

            if (start) begin
                burst_n    <= eff_count;
                period_cnt <= '0;
            end else if (period_end) begin
                period_cnt <= period_inc;
            end
        end
    end

    assign busy      = (state != ST_IDLE);
    assign cfg_ready = !pending;

endmodule

// File: tb/tb_thee_clk_pulse_gen.sv
// Directed self-checking bench for thee_clk_pulse_gen.
module tb_thee_clk_pulse_gen;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_high;
    logic [W-1:0] cfg_low;
    logic [W-1:0] cfg_count;
    logic         clk_out;
    logic         busy;
    logic         done;
    logic [W-1:0] period_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    thee_clk_pulse_gen #(.CNT_W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_high   (cfg_high),
        .cfg_low    (cfg_low),
        .cfg_count  (cfg_count),
        .clk_out    (clk_out),
        .busy       (busy),
        .done       (done),
        .period_cnt (period_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic offer_cfg(input int h, input int l, input int n);
        cfg_valid = 1'b1;
        cfg_high  = W'(h);
        cfg_low   = W'(l);
        cfg_count = W'(n);
    endtask

    // Run until IDLE (bounded), then expect the single done pulse.
    task automatic wait_idle(input string tag);
        int cyc;
        cyc = 0;
        while (busy !== 1'b0 && cyc < 64) begin
            step();
            cyc++;
        end
        check({tag, "_idle"}, busy, 0);
        check({tag, "_done"}, done, 1);
        check({tag, "_clkout"}, clk_out, 0);
        step();
        check({tag, "_done_gone"}, done, 0);
    endtask

    initial begin
        int highs;
        int rises;
        logic prev;

        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0;
        cfg_high = '0; cfg_low = '0; cfg_count = '0;
        step();
        step();
        rst = 1'b0;
        check("rst_clkout", clk_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pcnt", period_cnt, 0);
        check("rst_ready", cfg_ready, 1);

        // H=3 L=5 continuous
        offer_cfg(3, 5, 0);
        step();
        check("t1_ready_low", cfg_ready, 0);
        cfg_valid = 1'b0;
        en = 1'b1;
        step();
        highs = 0;
        for (int k = 0; k < 16; k++) begin
            check($sformatf("t1_wave%0d", k), clk_out, ((k % 8) < 3) ? 1 : 0);
            if (clk_out === 1'b1) highs++;
            step();
        end
        check("t1_duty_highs_of_16", highs, 6);
        check("t1_ready_back", cfg_ready, 1);
        en = 1'b0;
        wait_idle("t1");

        // H=2 L=2 N=4 burst with en held high
        offer_cfg(2, 2, 4);
        step();
        cfg_valid = 1'b0;
        en = 1'b1;
        step();
        rises = 0;
        prev = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check($sformatf("t2_wave%0d", k), clk_out, ((k % 4) < 2) ? 1 : 0);
            check($sformatf("t2_pcnt%0d", k), period_cnt, k / 4);
            if (clk_out === 1'b1 && prev === 1'b0) rises++;
            prev = clk_out;
            step();
        end
        en = 1'b0;
        check("t2_pulses", rises, 4);
        check("t2_busy", busy, 0);
        check("t2_done", done, 1);
        check("t2_pcnt_final", period_cnt, 4);
        check("t2_clkout", clk_out, 0);
        step();
        check("t2_done_gone", done, 0);
        check("t2_pcnt_hold", period_cnt, 4);

        // H=4 L=4, reconfigure to H=1 L=7 mid-HIGH
        offer_cfg(4, 4, 0);
        step();
        cfg_valid = 1'b0;
        en = 1'b1;
        step();
        check("t3_k0", clk_out, 1);
        step();
        check("t3_k1", clk_out, 1);
        offer_cfg(1, 7, 0);
        step();
        cfg_valid = 1'b0;
        for (int k = 2; k <= 16; k++) begin
            check($sformatf("t3_wave%0d", k), clk_out,
                  (k < 4) ? 1 : (k < 8) ? 0 : (k == 8) ? 1 : (k < 16) ? 0 : 1);
            check($sformatf("t3_ready%0d", k), cfg_ready, (k < 8) ? 0 : 1);
            if (k < 16) step();
        end
        en = 1'b0;
        wait_idle("t3");

        // H=3 L=3, en dropped in 2nd HIGH cycle
        offer_cfg(3, 3, 0);
        step();
        cfg_valid = 1'b0;
        en = 1'b1;
        step();
        check("t4_k0", clk_out, 1);
        step();
        check("t4_k1", clk_out, 1);
        en = 1'b0;
        for (int k = 2; k < 6; k++) begin
            step();
            check($sformatf("t4_wave%0d", k), clk_out, (k < 3) ? 1 : 0);
            check($sformatf("t4_busy%0d", k), busy, 1);
        end
        step();
        check("t4_idle", busy, 0);
        check("t4_done", done, 1);
        check("t4_clkout", clk_out, 0);
        step();
        check("t4_done_gone", done, 0);

        // H=0 L=0 -> 1/1, second offer held while pending
        offer_cfg(0, 0, 0);
        step();
        check("t5_ready_low", cfg_ready, 0);
        offer_cfg(2, 1, 0);
        en = 1'b1;
        step();
        check("t5_k0", clk_out, 1);
        check("t5_ready_k0", cfg_ready, 1);
        step();
        check("t5_k1", clk_out, 0);
        check("t5_ready_k1", cfg_ready, 0);
        cfg_valid = 1'b0;
        for (int k = 2; k < 8; k++) begin
            step();
            check($sformatf("t5_wave%0d", k), clk_out, (((k - 2) % 3) < 2) ? 1 : 0);
        end
        check("t5_ready_end", cfg_ready, 1);
        en = 1'b0;
        wait_idle("t5");

        // reset in LOW with a pending config
        offer_cfg(2, 4, 0);
        step();
        cfg_valid = 1'b0;
        en = 1'b1;
        step();
        step();
        step();
        check("t6_low", clk_out, 0);
        offer_cfg(3, 3, 0);
        step();
        check("t6_pending", cfg_ready, 0);
        cfg_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_clkout", clk_out, 0);
        check("t6_ready", cfg_ready, 1);
        check("t6_nodone", done, 0);
        check("t6_busy", busy, 0);
        check("t6_pcnt", period_cnt, 0);
        step();
        check("t6_r0", clk_out, 1);
        check("t6_nodone2", done, 0);
        step();
        check("t6_r1", clk_out, 0);
        step();
        check("t6_r2", clk_out, 1);
        step();
        check("t6_r3", clk_out, 0);
        en = 1'b0;
        wait_idle("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
